// File: rtl/ui_io_controller.sv
// Memory-mapped UI device block: debounced keys with sticky press capture and interrupt,
// synchronised switches, LED and 7-segment HEX registers, and a control register.
module ui_io_controller #(
  parameter int DBITS           = 32,
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int NLEDS           = 10,
  parameter int NHEX            = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         addr,
  input  logic               wrtEn,
  input  logic [DBITS-1:0]   in,
  output logic [DBITS-1:0]   out,
  output logic               irq,
  input  logic [NKEYS-1:0]   KEYS,
  input  logic [NSW-1:0]     SWITCHES,
  output logic [NLEDS-1:0]   LED,
  output logic [7*NHEX-1:0]  HEX_OUT
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_KEY     = 3'd0,
    REG_SW      = 3'd1,
    REG_LEDR    = 3'd2,
    REG_HEX     = 3'd3,
    REG_KEYEDGE = 3'd4,
    REG_CTRL    = 3'd5
  } reg_sel_e;

  // Key levels are held as 1 = pressed from the first synchroniser stage on.
  logic [NKEYS-1:0]  key_meta, key_sync, key_stable, key_edge, key_done, key_rise;
  logic [CW-1:0]     key_cnt [NKEYS];
  logic [NSW-1:0]    sw_meta, sw_sync;
  logic [NLEDS-1:0]  led_value;
  logic [4*NHEX-1:0] hex_value;
  logic [NKEYS:0]    ctrl;
  logic [DBITS-1:0]  rdata;
  logic              unused_in;

  assign unused_in = ^in;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NKEYS; i++)
      key_done[i] = (key_sync[i] != key_stable[i]) && (key_cnt[i] == CNT_MAX);
  end
  assign key_rise = key_done & key_sync;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta   <= '0;
      key_sync   <= '0;
      key_stable <= '0;
      sw_meta    <= '0;
      sw_sync    <= '0;
      // NOTE: the counter array is small and must restart from zero, so each entry is reset explicitly.
      for (int i = 0; i < NKEYS; i++) key_cnt[i] <= '0;
    end else begin
      key_meta <= ~KEYS;
      key_sync <= key_meta;
      sw_meta  <= SWITCHES;
      sw_sync  <= sw_meta;
      for (int i = 0; i < NKEYS; i++) begin
        if (key_sync[i] == key_stable[i]) begin
          key_cnt[i] <= '0;
        end else if (key_cnt[i] == CNT_MAX) begin
          key_stable[i] <= key_sync[i];
          key_cnt[i]    <= '0;
        end else begin
          key_cnt[i] <= key_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_value <= '0;
      hex_value <= '0;
      ctrl      <= '0;
      key_edge  <= '0;
    end else begin
      if (wrtEn && addr == REG_LEDR) led_value <= in[NLEDS-1:0];
      if (wrtEn && addr == REG_HEX)  hex_value <= in[4*NHEX-1:0];
      if (wrtEn && addr == REG_CTRL) ctrl      <= in[NKEYS:0];
      // A press landing on the same edge as its W1C survives.
      key_edge <= (key_edge & ~((wrtEn && addr == REG_KEYEDGE) ? in[NKEYS-1:0] : '0)) | key_rise;
    end
  end

  // NOTE: rdata gets a default before the case so no latch is inferred for unmapped addresses.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_KEY:     rdata[NKEYS-1:0]  = key_stable;
      REG_SW:      rdata[NSW-1:0]    = sw_sync;
      REG_LEDR:    rdata[NLEDS-1:0]  = led_value;
      REG_HEX:     rdata[4*NHEX-1:0] = hex_value;
      REG_KEYEDGE: rdata[NKEYS-1:0]  = key_edge;
      REG_CTRL:    rdata[NKEYS:0]    = ctrl;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= '0;
    else       out <= rdata;
  end

  assign irq = |(key_edge & ctrl[NKEYS-1:0]);
  assign LED = led_value;

  for (genvar g = 0; g < NHEX; g++) begin : g_digit
    assign HEX_OUT[7*g +: 7] = ctrl[NKEYS] ? 7'h7F : seg7(hex_value[4*g +: 4]);
  end

endmodule

// File: tb/tb_ui_io_controller.sv
// Bench for ui_io_controller: directed scenarios plus randomized traffic checked against a
// window-based behavioural model of the register file, key debouncing and switch sync.
module tb_ui_io_controller;

  localparam int DBITS = 32, NKEYS = 4, NSW = 10, NLEDS = 10, NHEX = 4, DC = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        addr = '0;
  logic              wrtEn = 1'b0;
  logic [DBITS-1:0]  in = '0;
  logic [DBITS-1:0]  out;
  logic              irq;
  logic [NKEYS-1:0]  KEYS = '1;
  logic [NSW-1:0]    SWITCHES = '0;
  logic [NLEDS-1:0]  LED;
  logic [7*NHEX-1:0] HEX_OUT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ui_io_controller #(
    .DBITS(DBITS), .NKEYS(NKEYS), .NSW(NSW), .NLEDS(NLEDS), .NHEX(NHEX), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .in(in), .out(out), .irq(irq),
    .KEYS(KEYS), .SWITCHES(SWITCHES), .LED(LED), .HEX_OUT(HEX_OUT)
  );

  // Behavioural model: a key level is accepted once the synchronised pin has shown the
  // same new level for DC consecutive cycles (window over pin history).
  logic [NLEDS-1:0]  m_led;
  logic [4*NHEX-1:0] m_hex;
  logic [NKEYS:0]    m_ctrl;
  logic [NKEYS-1:0]  m_edge, m_key, m_rise, m_clr;
  logic [NKEYS-1:0]  kh [DC+2];
  logic [NSW-1:0]    sh [2];
  logic [DBITS-1:0]  m_out;
  logic              steady;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;  4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;  4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;  4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;  4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;  4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*NHEX-1:0] exp_hex();
    logic [7*NHEX-1:0] r;
    for (int d = 0; d < NHEX; d++) r[7*d +: 7] = m_ctrl[NKEYS] ? 7'h7F : seg_ref(m_hex[4*d +: 4]);
    return r;
  endfunction

  function automatic logic [DBITS-1:0] model_read(input logic [2:0] a);
    logic [DBITS-1:0] r;
    r = '0;
    case (a)
      3'd0: r[NKEYS-1:0]  = m_key;
      3'd1: r[NSW-1:0]    = sh[1];
      3'd2: r[NLEDS-1:0]  = m_led;
      3'd3: r[4*NHEX-1:0] = m_hex;
      3'd4: r[NKEYS-1:0]  = m_edge;
      3'd5: r[NKEYS:0]    = m_ctrl;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_led = '0; m_hex = '0; m_ctrl = '0; m_edge = '0; m_key = '0; m_out = '0;
      for (int j = 0; j < DC + 2; j++) kh[j] = '0;
      sh[0] = '0; sh[1] = '0;
    end else begin
      m_out = model_read(addr);
      for (int j = DC + 1; j > 0; j--) kh[j] = kh[j-1];
      kh[0] = ~KEYS;
      sh[1] = sh[0];
      sh[0] = SWITCHES;
      m_rise = '0;
      for (int k = 0; k < NKEYS; k++) begin
        steady = 1'b1;
        for (int j = 3; j < DC + 2; j++) if (kh[j][k] != kh[2][k]) steady = 1'b0;
        if (steady && kh[2][k] != m_key[k]) begin
          m_key[k] = kh[2][k];
          if (kh[2][k]) m_rise[k] = 1'b1;
        end
      end
      m_clr  = (wrtEn && addr == 3'd4) ? in[NKEYS-1:0] : '0;
      m_edge = (m_edge & ~m_clr) | m_rise;
      if (wrtEn && addr == 3'd2) m_led  = in[NLEDS-1:0];
      if (wrtEn && addr == 3'd3) m_hex  = in[4*NHEX-1:0];
      if (wrtEn && addr == 3'd5) m_ctrl = in[NKEYS:0];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [DBITS-1:0] d);
    addr = a; in = d; wrtEn = 1'b1;
    tick(1);
    wrtEn = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [DBITS-1:0] d);
    addr = a; wrtEn = 1'b0;
    tick(1);
    d = out;
  endtask

  task automatic test_reset();
    logic [DBITS-1:0] d;
    reset = 1'b1;
    tick(2);
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
    n_checks++; if (HEX_OUT !== {NHEX{7'h40}}) begin n_fail++; $display("FAIL reset_hex: got %h want %h", HEX_OUT, {NHEX{7'h40}}); end
    reset = 1'b0;
    wr(3'd2, 32'h3FF);
    wr(3'd3, 32'hBEEF);
    KEYS[0] = 1'b0;
    rd(3'd2, d);
    n_checks++; if (d !== 32'h3FF) begin n_fail++; $display("FAIL led_read: got %h want 3ff", d); end
    tick(3);
    reset = 1'b1;
    #1;
    n_checks++; if (LED !== '0) begin n_fail++; $display("FAIL midop_led: got %h want 0", LED); end
    n_checks++; if (HEX_OUT !== {NHEX{7'h40}}) begin n_fail++; $display("FAIL midop_hex: got %h want %h", HEX_OUT, {NHEX{7'h40}}); end
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL midop_out: got %h want 0", out); end
    KEYS = '1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_debounce();
    logic [DBITS-1:0] d;
    addr = 3'd0;
    KEYS[1] = 1'b0;
    tick(5);
    KEYS[1] = 1'b1;
    tick(20);
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL glitch_key: got %h want 0", out); end
    rd(3'd4, d);
    n_checks++; if (d !== '0) begin n_fail++; $display("FAIL glitch_edge: got %h want 0", d); end
    addr = 3'd0;
    KEYS[1] = 1'b0;
    tick(DC + 2);
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL press_early: got %h want 0", out); end
    tick(1);
    n_checks++; if (out !== 32'h2) begin n_fail++; $display("FAIL press_key: got %h want 2", out); end
    tick(1);
    KEYS[1] = 1'b1;
    rd(3'd4, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL press_edge: got %h want 2", d); end
    wr(3'd4, 32'hF);
    tick(DC + 4);
  endtask

  task automatic test_edge_irq();
    wr(3'd5, 32'h2);
    KEYS[1] = 1'b0;
    tick(DC + 6);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
    wr(3'd4, 32'h1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_other_clr: got %b want 1", irq); end
    wr(3'd4, 32'h2);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b want 0", irq); end
    KEYS[1] = 1'b1;
    tick(DC + 4);
    wr(3'd5, 32'h0);
  endtask

  task automatic test_collision();
    logic [DBITS-1:0] d;
    wr(3'd4, 32'hF);
    KEYS[2] = 1'b0;
    tick(DC + 1);
    addr = 3'd4; in = 32'h4; wrtEn = 1'b1;
    tick(1);
    wrtEn = 1'b0;
    rd(3'd4, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL collision_keep: got %h want 4", d); end
    wr(3'd4, 32'h4);
    rd(3'd4, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL collision_later_clr: got %h want 0", d); end
    KEYS[2] = 1'b1;
    tick(DC + 4);
  endtask

  task automatic test_reg_map();
    logic [DBITS-1:0] d;
    wr(3'd3, 32'h12345);
    rd(3'd3, d);
    n_checks++; if (d !== 32'h2345) begin n_fail++; $display("FAIL hex_read: got %h want 2345", d); end
    n_checks++; if (HEX_OUT !== {7'h24, 7'h30, 7'h19, 7'h12}) begin n_fail++; $display("FAIL hex_digits: got %h want %h", HEX_OUT, {7'h24, 7'h30, 7'h19, 7'h12}); end
    wr(3'd5, 32'h10);
    n_checks++; if (HEX_OUT !== {NHEX{7'h7F}}) begin n_fail++; $display("FAIL hex_blank: got %h want %h", HEX_OUT, {NHEX{7'h7F}}); end
    rd(3'd3, d);
    n_checks++; if (d !== 32'h2345) begin n_fail++; $display("FAIL hex_blank_read: got %h want 2345", d); end
    rd(3'd5, d);
    n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL ctrl_read: got %h want 10", d); end
    wr(3'd5, 32'h0);
    wr(3'd2, 32'hFFFF_F155);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, d);
    n_checks++; if (d !== '0) begin n_fail++; $display("FAIL key_ro: got %h want 0", d); end
    rd(3'd1, d);
    n_checks++; if (d !== '0) begin n_fail++; $display("FAIL sw_ro: got %h want 0", d); end
    rd(3'd6, d);
    n_checks++; if (d !== '0) begin n_fail++; $display("FAIL unmapped6: got %h want 0", d); end
    rd(3'd7, d);
    n_checks++; if (d !== '0) begin n_fail++; $display("FAIL unmapped7: got %h want 0", d); end
    rd(3'd2, d);
    n_checks++; if (d !== 32'h155) begin n_fail++; $display("FAIL led_trunc: got %h want 155", d); end
    n_checks++; if (LED !== 10'h155) begin n_fail++; $display("FAIL led_pins: got %h want 155", LED); end
  endtask

  task automatic test_switches();
    addr = 3'd1;
    SWITCHES = 10'h2A5;
    tick(2);
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL sw_early: got %h want 0", out); end
    tick(1);
    n_checks++; if (out !== 32'h2A5) begin n_fail++; $display("FAIL sw_read: got %h want 2a5", out); end
  endtask

  task automatic test_random(input int cycles);
    int hold [NKEYS];
    for (int k = 0; k < NKEYS; k++) hold[k] = 1;
    for (int c = 0; c < cycles; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      addr  = 3'($urandom_range(0, 7));
      wrtEn = 1'($urandom_range(0, 1));
      in    = $urandom;
      if ($urandom_range(0, 15) == 0) SWITCHES = NSW'($urandom);
      for (int k = 0; k < NKEYS; k++) begin
        hold[k]--;
        if (hold[k] == 0) begin
          KEYS[k] = ~KEYS[k];
          hold[k] = $urandom_range(1, 2 * DC + 4);
        end
      end
      @(negedge clk);
      n_checks++; if (out !== m_out) begin n_fail++; $display("FAIL rand_out c%0d: got %h want %h", c, out, m_out); end
      n_checks++; if (LED !== m_led) begin n_fail++; $display("FAIL rand_led c%0d: got %h want %h", c, LED, m_led); end
      n_checks++; if (HEX_OUT !== exp_hex()) begin n_fail++; $display("FAIL rand_hex c%0d: got %h want %h", c, HEX_OUT, exp_hex()); end
      n_checks++; if (irq !== |(m_edge & m_ctrl[NKEYS-1:0])) begin n_fail++; $display("FAIL rand_irq c%0d: got %b want %b", c, irq, |(m_edge & m_ctrl[NKEYS-1:0])); end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    wrtEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_edge_irq();
    test_collision();
    test_reg_map();
    test_switches();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
